// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
//   Handshake and operand/result bundle for the sequential restoring divider.
//   The clock and reset are kept outside the bundle as plain module ports.
//
//   Signals
//     START     request, honoured only while READY is high
//     DIVIDEND  unsigned dividend (N_W bits), sampled with an accepted START
//     DIVISOR   unsigned divisor (D_W bits), sampled with an accepted START
//     READY     divider is idle and can take a new request
//     BUSY      divider is iterating
//     DONE      one-cycle pulse, QUOT/REM/DIVZ are valid
//     QUOT      quotient (N_W bits), held until the next accepted START
//     REM       remainder (D_W bits), held until the next accepted START
//     DIVZ      divide-by-zero flag for the current result
//
//   Modports
//     master    the requester (drives START and the operands)
//     slave     the divider itself
// -----------------------------------------------------------------------------
interface seq_divider_if #(
  parameter int N_W = 16,
  parameter int D_W = 8
);

  logic           START;
  logic [N_W-1:0] DIVIDEND;
  logic [D_W-1:0] DIVISOR;
  logic           READY;
  logic           BUSY;
  logic           DONE;
  logic [N_W-1:0] QUOT;
  logic [D_W-1:0] REM;
  logic           DIVZ;

  modport master (
    output START, DIVIDEND, DIVISOR,
    input  READY, BUSY, DONE, QUOT, REM, DIVZ
  );

  modport slave (
    input  START, DIVIDEND, DIVISOR,
    output READY, BUSY, DONE, QUOT, REM, DIVZ
  );

endinterface

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Sequential radix-2 restoring divider. Divides an N_W-bit unsigned dividend
//   by a D_W-bit unsigned divisor, producing one quotient bit per clock behind
//   a START/DONE handshake. Companion of the 8x8 multiplier: a 16-bit product
//   divided by one of its factors gives the other factor back.
//
//   Parameters
//     N_W   dividend and quotient width (must be >= D_W)
//     D_W   divisor and remainder width
//
//   Ports
//     CLK   sole clock, rising edge
//     RST   synchronous, active-high reset; dominates every state
//     bus   seq_divider_if slave modport (START/operands in, READY/BUSY/DONE
//           and QUOT/REM/DIVZ out)
//
//   Timing
//     START accepted in cycle 0 -> BUSY in cycles 1..N_W, DONE in cycle N_W+1,
//     READY again in cycle N_W+2. A zero divisor skips the iteration: DONE and
//     DIVZ in cycle 1, READY in cycle 2.
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int N_W = 16,
  parameter int D_W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  seq_divider_if.slave bus
);

  // Wide enough to hold N_W itself, so the counter never needs to wrap.
  localparam int CNT_W = $clog2(N_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_e;

  state_e           state_q;
  logic [D_W-1:0]   divisor_q;
  logic [N_W-1:0]   quotShift_q;
  logic [D_W:0]     partRem_q;
  logic [CNT_W-1:0] count_q;
  logic             divz_q;

  logic [D_W+1:0]   remShifted;
  logic             trialFits;
  logic [D_W:0]     trialDiff;
  logic [D_W:0]     partRem_d;
  logic [N_W-1:0]   quotShift_d;

  // One restoring step. The {P,Q} pair is shifted left by one bit, then the
  // divisor is trial-subtracted from the new partial remainder. The shifted
  // value is kept one bit wider than P so the compare sees every bit of P;
  // because P < divisor between steps, the shifted value is below twice the
  // divisor and the difference always fits back into D_W+1 bits.
  always_comb begin
    remShifted  = {partRem_q, quotShift_q[N_W-1]};
    trialFits   = (remShifted >= {2'b00, divisor_q});
    trialDiff   = remShifted[D_W:0] - {1'b0, divisor_q};
    partRem_d   = trialFits ? trialDiff : remShifted[D_W:0];
    quotShift_d = {quotShift_q[N_W-2:0], trialFits};
  end

  // Control FSM plus the datapath registers. The quotient shift register
  // starts out holding the dividend; its bits are consumed from the top as
  // quotient bits enter at the bottom, so after N_W steps it holds the
  // quotient. A zero divisor bypasses the loop and loads the flagged result
  // straight away. Reset discards any in-flight operation with no DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      divisor_q   <= '0;
      quotShift_q <= '0;
      partRem_q   <= '0;
      count_q     <= '0;
      divz_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.START) begin
            if (bus.DIVISOR != '0) begin
              divisor_q   <= bus.DIVISOR;
              quotShift_q <= bus.DIVIDEND;
              partRem_q   <= '0;
              count_q     <= '0;
              divz_q      <= 1'b0;
              state_q     <= RUN;
            end else begin
              quotShift_q <= '1;
              partRem_q   <= {1'b0, bus.DIVIDEND[D_W-1:0]};
              divz_q      <= 1'b1;
              state_q     <= FIN;
            end
          end
        end

        RUN: begin
          partRem_q   <= partRem_d;
          quotShift_q <= quotShift_d;
          count_q     <= count_q + CNT_W'(1);
          if (count_q == LAST_ITER) begin
            state_q <= FIN;
          end
        end

        FIN: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Status is a pure decode of the state register, so READY/BUSY/DONE are
  // mutually exclusive and have no path from the inputs.
  assign bus.READY = (state_q == IDLE);
  assign bus.BUSY  = (state_q == RUN);
  assign bus.DONE  = (state_q == FIN);

  // The final remainder is below the divisor, so the top bit of P is dropped.
  assign bus.QUOT  = quotShift_q;
  assign bus.REM   = partRem_q[D_W-1:0];
  assign bus.DIVZ  = divz_q;

endmodule
